// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 timing for the VGA stream output stage.
package vga_pkg;

   typedef enum logic {
      SEEK   = 1'b0,
      STREAM = 1'b1
   } state_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // Pin level for a sync pulse given whether it is asserted and the asserted polarity.
   function automatic logic sync_level(input logic asserted, input logic pol);
      return asserted ? pol : ~pol;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster generator: h/v counters, active window, sync levels
// and the last-pixel-of-frame strobe, all decoded from the current counters.
module vga_timing
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0,
   localparam int  H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int  V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int  HW       = $clog2(H_TOTAL),
   localparam int  VW       = $clog2(V_TOTAL)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   output logic [HW-1:0] o_h_cnt,
   output logic [VW-1:0] o_v_cnt,
   output logic          o_active,
   output logic          o_hsync,
   output logic          o_vsync,
   output logic          o_frame_end
);

   localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] r_h_cnt;
   logic [VW-1:0] r_v_cnt;
   logic          w_h_wrap;
   logic          w_v_wrap;

   assign w_h_wrap = (r_h_cnt == H_LAST);
   assign w_v_wrap = (r_v_cnt == V_LAST);

   // Raster counters: never stall, v advances on the horizontal wrap.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_h_wrap) begin
         r_h_cnt <= '0;
         if (w_v_wrap) begin
            r_v_cnt <= '0;
         end else begin
            r_v_cnt <= r_v_cnt + VW'(1);
         end
      end else begin
         r_h_cnt <= r_h_cnt + HW'(1);
      end
   end

   assign o_h_cnt     = r_h_cnt;
   assign o_v_cnt     = r_v_cnt;
   assign o_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
   assign o_hsync     = sync_level((r_h_cnt >= H_SS) && (r_h_cnt < H_SE), SYNC_POL);
   assign o_vsync     = sync_level((r_v_cnt >= V_SS) && (r_v_cnt < V_SE), SYNC_POL);
   assign o_frame_end = w_h_wrap && w_v_wrap;

endmodule

// File: rtl/vga_stream_out.sv
// RGB444 stream to VGA pins: locks the stream to the raster at frame start,
// drops back to SEEK on underflow or misaligned markers, and keeps sticky flags.
module vga_stream_out
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE = DEF_H_ACTIVE,
   parameter int   H_FP     = DEF_H_FP,
   parameter int   H_SYNC   = DEF_H_SYNC,
   parameter int   H_BP     = DEF_H_BP,
   parameter int   V_ACTIVE = DEF_V_ACTIVE,
   parameter int   V_FP     = DEF_V_FP,
   parameter int   V_SYNC   = DEF_V_SYNC,
   parameter int   V_BP     = DEF_V_BP,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic [11:0] s_tdata,
   input  logic        s_tvalid,
   output logic        s_tready,
   input  logic        s_tuser,
   input  logic        s_tlast,
   input  logic        err_clr,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hsync,
   output logic        vga_vsync,
   output logic        err_underflow,
   output logic        err_align,
   output logic        locked
);

   localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
   localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
   localparam logic [HW-1:0] H_LINE_END = HW'(H_ACTIVE - 1);

   logic [HW-1:0] w_h_cnt;
   logic [VW-1:0] w_v_cnt;
   logic          w_active;
   logic          w_hsync;
   logic          w_vsync;
   logic          w_frame_end;

   state_t  r_state;
   state_t  w_state_next;
   rgb444_t r_rgb;
   rgb444_t w_rgb_next;
   logic    w_tready;
   logic    w_accept;
   logic    w_at_origin;
   logic    w_set_under;
   logic    w_set_align;
   logic    r_hsync;
   logic    r_vsync;
   logic    r_err_under;
   logic    r_err_align;
   logic    r_locked;

   vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP),
      .SYNC_POL (SYNC_POL)
   ) u_timing (
      .i_clk       (sys_clk),
      .i_rst       (sys_rst),
      .o_h_cnt     (w_h_cnt),
      .o_v_cnt     (w_v_cnt),
      .o_active    (w_active),
      .o_hsync     (w_hsync),
      .o_vsync     (w_vsync),
      .o_frame_end (w_frame_end)
   );

   assign w_accept    = s_tvalid && w_tready;
   assign w_at_origin = (w_h_cnt == '0) && (w_v_cnt == '0);

   // Next state, handshake, pixel select and error detection.
   always_comb begin
      w_state_next = r_state;
      w_tready     = 1'b0;
      w_rgb_next   = '0;
      w_set_under  = 1'b0;
      w_set_align  = 1'b0;
      case (r_state)
         SEEK: begin
            // Discard stray beats but hold the SOF until the raster reaches (0,0).
            w_tready = ~s_tuser;
            if (s_tvalid && s_tuser && w_frame_end) begin
               w_state_next = STREAM;
            end else begin
               w_state_next = SEEK;
            end
         end
         STREAM: begin
            w_tready    = w_active;
            w_set_under = w_active && !s_tvalid;
            w_set_align = w_accept &&
                          ((s_tuser && !w_at_origin) || (s_tlast != (w_h_cnt == H_LINE_END)));
            if (w_accept) begin
               w_rgb_next = rgb444_t'(s_tdata);
            end else begin
               w_rgb_next = '0;
            end
            if (w_set_under || w_set_align) begin
               w_state_next = SEEK;
            end else begin
               w_state_next = STREAM;
            end
         end
         default: begin
            w_state_next = SEEK;
         end
      endcase
   end

   // State and pin registers; a new error outranks a coincident clear.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state     <= SEEK;
         r_rgb       <= '0;
         r_hsync     <= ~SYNC_POL;
         r_vsync     <= ~SYNC_POL;
         r_err_under <= 1'b0;
         r_err_align <= 1'b0;
         r_locked    <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_rgb       <= w_rgb_next;
         r_hsync     <= w_hsync;
         r_vsync     <= w_vsync;
         r_err_under <= w_set_under | (r_err_under & ~err_clr);
         r_err_align <= w_set_align | (r_err_align & ~err_clr);
         r_locked    <= (w_state_next == STREAM);
      end
   end

   assign s_tready      = w_tready & ~sys_rst;
   assign vga_r         = r_rgb.r;
   assign vga_g         = r_rgb.g;
   assign vga_b         = r_rgb.b;
   assign vga_hsync     = r_hsync;
   assign vga_vsync     = r_vsync;
   assign err_underflow = r_err_under;
   assign err_align     = r_err_align;
   assign locked        = r_locked;

endmodule

// File: tb/tb_vga_stream_out.sv
// Directed bench for vga_stream_out on a reduced 14x7 raster.
module tb_vga_stream_out;

   localparam int FRAME = 98;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic [11:0] s_tdata = 12'h000;
   logic        s_tvalid = 1'b0;
   logic        s_tready;
   logic        s_tuser = 1'b0;
   logic        s_tlast = 1'b0;
   logic        err_clr = 1'b0;
   logic [3:0]  vga_r, vga_g, vga_b;
   logic        vga_hsync, vga_vsync;
   logic        err_underflow, err_align, locked;

   int  errors = 0;
   int  checks = 0;
   int  pos = 0;
   int  pos_prev = 0;
   bit  acc = 1'b0;

   vga_stream_out #(
      .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
      .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
      .SYNC_POL (1'b0)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst       (sys_rst),
      .s_tdata       (s_tdata),
      .s_tvalid      (s_tvalid),
      .s_tready      (s_tready),
      .s_tuser       (s_tuser),
      .s_tlast       (s_tlast),
      .err_clr       (err_clr),
      .vga_r         (vga_r),
      .vga_g         (vga_g),
      .vga_b         (vga_b),
      .vga_hsync     (vga_hsync),
      .vga_vsync     (vga_vsync),
      .err_underflow (err_underflow),
      .err_align     (err_align),
      .locked        (locked)
   );

   always #5 sys_clk = ~sys_clk;

   // One raster cycle: present inputs, note acceptance, pass the edge.
   task automatic drive_cycle(input logic v, input logic u, input logic l,
                              input logic [11:0] d, input logic clr);
      s_tvalid = v; s_tuser = u; s_tlast = l; s_tdata = d; err_clr = clr;
      #1;
      acc = v && s_tready;
      @(posedge sys_clk);
      #1;
      pos_prev = pos;
      pos = (pos + 1) % FRAME;
   endtask

   task automatic do_reset();
      @(posedge sys_clk);
      #1;
      sys_rst = 1'b1;
      s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 12'h000; err_clr = 1'b0;
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
      pos = 0;
   endtask

   task automatic test_reset();
      int h, v;
      repeat (2) @(posedge sys_clk);
      #1;
      checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++; $display("FAIL reset_rgb got %h want 000", {vga_r, vga_g, vga_b}); end
      checks++; if (vga_hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync got %b want 1", vga_hsync); end
      checks++; if (vga_vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync got %b want 1", vga_vsync); end
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL reset_tready got %b want 0", s_tready); end
      checks++; if ({err_underflow, err_align, locked} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {err_underflow, err_align, locked}); end
      sys_rst = 1'b0;
      pos = 0;
      for (int c = 0; c < 2 * FRAME; c++) begin
         drive_cycle(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
         h = pos_prev % 14;
         v = pos_prev / 14;
         checks++; if (vga_hsync !== ((h == 10 || h == 11) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL hsync_timing at h=%0d v=%0d got %b", h, v, vga_hsync); end
         checks++; if (vga_vsync !== ((v == 5) ? 1'b0 : 1'b1)) begin errors++; $display("FAIL vsync_timing at h=%0d v=%0d got %b", h, v, vga_vsync); end
      end
   endtask

   task automatic test_stream();
      int holds = 0, idx, ph, pv, exp;
      bit got = 1'b0;
      do_reset();
      for (int c = 0; c < 300 && !got; c++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
         if (acc) got = 1'b1; else holds++;
      end
      checks++; if (holds !== 98 || pos_prev !== 0) begin errors++; $display("FAIL stream_sof_hold got holds=%0d pos=%0d want 98 0", holds, pos_prev); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL stream_locked got %b want 1", locked); end
      idx = 1;
      for (int c = 0; c < FRAME - 1; c++) begin
         if (idx < 32) drive_cycle(1'b1, 1'b0, (idx % 8) == 7, 12'(idx), 1'b0);
         else drive_cycle(1'b0, 1'b0, 1'b0, 12'h000, 1'b0);
         if (acc) idx++;
         ph = pos_prev % 14;
         pv = pos_prev / 14;
         exp = (ph < 8 && pv < 4) ? pv * 8 + ph : 0;
         checks++; if ({vga_r, vga_g, vga_b} !== 12'(exp)) begin errors++; $display("FAIL stream_rgb at h=%0d v=%0d got %h want %h", ph, pv, {vga_r, vga_g, vga_b}, 12'(exp)); end
      end
      checks++; if (idx !== 32) begin errors++; $display("FAIL stream_count got %0d want 32", idx); end
      checks++; if ({err_underflow, err_align, locked} !== 3'b001) begin errors++; $display("FAIL stream_flags got %b want 001", {err_underflow, err_align, locked}); end
   endtask

   task automatic test_seek_discard();
      int holds = 0;
      bit got = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b1, 1'b0, 1'b0, 12'hA00 + 12'(i), 1'b0);
         checks++; if (acc !== 1'b1) begin errors++; $display("FAIL seek_discard beat %0d not consumed", i); end
         checks++; if ({vga_r, vga_g, vga_b, locked} !== 13'h0) begin errors++; $display("FAIL seek_black got %h want 0000", {vga_r, vga_g, vga_b, locked}); end
      end
      for (int c = 0; c < 300 && !got; c++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 12'h5A3, 1'b0);
         if (acc) got = 1'b1; else holds++;
      end
      checks++; if (holds !== 93 || pos_prev !== 0) begin errors++; $display("FAIL seek_sof_hold got holds=%0d pos=%0d want 93 0", holds, pos_prev); end
      checks++; if ({vga_r, vga_g, vga_b} !== 12'h5A3) begin errors++; $display("FAIL seek_sof_pixel got %h want 5a3", {vga_r, vga_g, vga_b}); end
      checks++; if (locked !== 1'b1) begin errors++; $display("FAIL seek_locked got %b want 1", locked); end
   endtask

   task automatic test_underflow();
      int idx = 0, discards = 0;
      bit lk = 1'b0, dropped = 1'b0, relocked = 1'b0, drop;
      do_reset();
      for (int c = 0; c < 400 && !relocked; c++) begin
         drop = lk && !dropped && (pos == 2 * 14 + 3);
         drive_cycle(!drop, idx == 0, (idx % 8) == 7, 12'h100 + 12'(idx), 1'b0);
         if (drop) begin
            dropped = 1'b1;
            lk = 1'b0;
            checks++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin errors++; $display("FAIL under_black got %h want 000", {vga_r, vga_g, vga_b}); end
            checks++; if ({err_underflow, locked} !== 2'b10) begin errors++; $display("FAIL under_flag got %b want 10", {err_underflow, locked}); end
         end else if (acc) begin
            if (idx == 0) begin
               if (dropped) relocked = 1'b1;
               lk = 1'b1;
            end else if (dropped && !lk) begin
               discards++;
            end
            if (!dropped && pos_prev == 2 * 14 + 2) begin
               checks++; if ({vga_r, vga_g, vga_b} !== 12'h112) begin errors++; $display("FAIL under_prev_pixel got %h want 112", {vga_r, vga_g, vga_b}); end
            end
            idx = (idx + 1) % 32;
         end
      end
      checks++; if (!relocked || discards !== 13) begin errors++; $display("FAIL under_relock got relock=%0d discards=%0d want 1 13", relocked, discards); end
      checks++; if ({err_underflow, locked} !== 2'b11) begin errors++; $display("FAIL under_sticky got %b want 11", {err_underflow, locked}); end
      drive_cycle(1'b1, 1'b0, 1'b0, 12'h101, 1'b1);
      checks++; if ({err_underflow, err_align, locked} !== 3'b001) begin errors++; $display("FAIL under_clear got %b want 001", {err_underflow, err_align, locked}); end
   endtask

   task automatic test_align();
      int idx = 0;
      bit lk = 1'b0, errd = 1'b0, relocked = 1'b0, bad;
      do_reset();
      for (int c = 0; c < 400 && !relocked; c++) begin
         bad = lk && !errd && (pos == 1 * 14 + 6);
         drive_cycle(1'b1, idx == 0, bad ? 1'b1 : ((idx % 8) == 7), 12'h200 + 12'(idx), 1'b0);
         if (bad) begin
            errd = 1'b1;
            lk = 1'b0;
            checks++; if (acc !== 1'b1) begin errors++; $display("FAIL align_consumed got %b want 1", acc); end
            checks++; if ({err_align, err_underflow, locked} !== 3'b100) begin errors++; $display("FAIL align_flag got %b want 100", {err_align, err_underflow, locked}); end
         end else if (acc && idx == 0) begin
            if (errd) relocked = 1'b1;
            lk = 1'b1;
         end
         if (acc) idx = (idx + 1) % 32;
      end
      checks++; if (!relocked || locked !== 1'b1) begin errors++; $display("FAIL align_relock got relock=%0d locked=%b want 1 1", relocked, locked); end
      drive_cycle(1'b1, 1'b1, 1'b0, 12'h3C3, 1'b1);
      checks++; if ({acc, err_align, locked} !== 3'b110) begin errors++; $display("FAIL align_set_wins got %b want 110", {acc, err_align, locked}); end
   endtask

   task automatic test_midframe_reset();
      int idx = 0, holds = 0;
      bit lk = 1'b0, got = 1'b0;
      do_reset();
      for (int c = 0; c < 400 && !(lk && pos == 2 * 14 + 5); c++) begin
         drive_cycle(1'b1, idx == 0, (idx % 8) == 7, 12'hF00 + 12'(idx), 1'b0);
         if (acc) begin
            if (idx == 0) lk = 1'b1;
            idx = (idx + 1) % 32;
         end
      end
      checks++; if ({locked, vga_r, vga_g, vga_b} !== {1'b1, 12'hF14}) begin errors++; $display("FAIL rst_pre_state got %h want 1f14", {locked, vga_r, vga_g, vga_b}); end
      s_tvalid = 1'b1; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 12'hF15;
      sys_rst = 1'b1;
      #1;
      checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", s_tready); end
      @(posedge sys_clk);
      #1;
      checks++; if ({vga_r, vga_g, vga_b, vga_hsync, vga_vsync} !== 14'b00000000000011) begin errors++; $display("FAIL rst_pins got %b want 00000000000011", {vga_r, vga_g, vga_b, vga_hsync, vga_vsync}); end
      checks++; if ({err_underflow, err_align, locked} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {err_underflow, err_align, locked}); end
      sys_rst = 1'b0;
      pos = 0;
      for (int c = 0; c < 300 && !got; c++) begin
         drive_cycle(1'b1, 1'b1, 1'b0, 12'h0F0, 1'b0);
         if (acc) got = 1'b1; else holds++;
      end
      checks++; if (holds !== 98 || locked !== 1'b1) begin errors++; $display("FAIL rst_relock got holds=%0d locked=%b want 98 1", holds, locked); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_seek_discard();
      test_underflow();
      test_align();
      test_midframe_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
